// File: rtl/lsu_byte_master.sv
// ============================================================================
// Module  : lsu_byte_master
// Purpose : Splits byte/half/word loads and stores into byte-wide req/ack
//           transactions, assembles and extends load data, bounds each wait.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_byte_master #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic        i_req_write,
    input  logic [1:0]  i_req_type,
    input  logic        i_req_unsigned,

    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,

    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [7:0]  i_mem_rdata
);

    localparam logic [1:0] c_TYPE_BYTE = 2'b00;
    localparam logic [1:0] c_TYPE_HALF = 2'b01;
    localparam logic [1:0] c_TYPE_WORD = 2'b10;
    localparam logic [1:0] c_TYPE_ILL  = 2'b11;

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] c_WAIT_LAST =
        (MAX_WAIT > 0) ? WAIT_W'(MAX_WAIT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                r_write;
    logic [1:0]          r_type;
    logic                r_unsigned;
    logic [1:0]          r_idx;
    logic [WAIT_W-1:0]   r_wait;
    logic [31:0]         r_asm;
    logic [31:0]         r_rdata;
    logic                r_err;

    logic                w_accept;
    logic                w_ack;
    logic                w_last;
    logic                w_timeout;
    logic [1:0]          w_last_idx;
    logic [31:0]         w_asm_next;
    logic [31:0]         w_load_ext;

    always_comb begin
        w_last_idx = 2'd0;
        case (r_type)
            c_TYPE_HALF: w_last_idx = 2'd1;
            c_TYPE_WORD: w_last_idx = 2'd3;
            default:     w_last_idx = 2'd0;
        endcase
    end

    assign w_accept  = (r_state == S_IDLE) && i_req_valid;
    assign w_ack     = (r_state == S_ISSUE) && i_mem_ack;
    assign w_last    = (r_idx == w_last_idx);
    assign w_timeout = (MAX_WAIT != 0) && (r_state == S_ISSUE) && !i_mem_ack
                       && (r_wait == c_WAIT_LAST);

    // Current ack byte merged in so the final byte is extended in the same cycle
    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[{r_idx, 3'b000} +: 8] = i_mem_rdata;
    end

    always_comb begin
        w_load_ext = w_asm_next;
        case (r_type)
            c_TYPE_BYTE: w_load_ext = {{24{!r_unsigned && w_asm_next[7]}},  w_asm_next[7:0]};
            c_TYPE_HALF: w_load_ext = {{16{!r_unsigned && w_asm_next[15]}}, w_asm_next[15:0]};
            default:     w_load_ext = w_asm_next;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_req_ready  = 1'b0;
        o_mem_req    = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_addr   = 32'd0;
        o_mem_wdata  = 8'd0;
        o_resp_valid = 1'b0;
        o_resp_rdata = 32'd0;
        o_resp_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = (i_req_type == c_TYPE_ILL) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_mem_req  = 1'b1;
                o_mem_we   = r_write;
                o_mem_addr = r_addr + {30'd0, r_idx};
                if (r_write) begin
                    o_mem_wdata = r_wdata[{r_idx, 3'b000} +: 8];
                end
                if ((w_ack && w_last) || w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                o_resp_rdata = r_rdata;
                o_resp_err   = r_err;
                if (i_resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_write    <= 1'b0;
            r_type     <= 2'b00;
            r_unsigned <= 1'b0;
            r_idx      <= 2'd0;
            r_wait     <= '0;
            r_asm      <= 32'd0;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= i_req_addr;
                        r_wdata    <= i_req_wdata;
                        r_write    <= i_req_write;
                        r_type     <= i_req_type;
                        r_unsigned <= i_req_unsigned;
                        r_idx      <= 2'd0;
                        r_wait     <= '0;
                        r_asm      <= 32'd0;
                        r_rdata    <= 32'd0;
                        r_err      <= (i_req_type == c_TYPE_ILL);
                    end
                end
                S_ISSUE: begin
                    if (w_ack) begin
                        r_wait <= '0;
                        if (!r_write) begin
                            r_asm <= w_asm_next;
                        end
                        if (w_last) begin
                            r_rdata <= r_write ? 32'd0 : w_load_ext;
                            r_err   <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                        // Abort leaves already-written bytes in place
                        if (w_timeout) begin
                            r_rdata <= 32'd0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_byte_master.sv
// ============================================================================
// Module  : tb_lsu_byte_master
// Purpose : Directed self-checking bench for lsu_byte_master with a byte memory model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_byte_master;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [31:0] i_req_addr = 32'd0;
    logic [31:0] i_req_wdata = 32'd0;
    logic        i_req_write = 1'b0;
    logic [1:0]  i_req_type = 2'b00;
    logic        i_req_unsigned = 1'b0;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b0;
    logic [31:0] o_resp_rdata;
    logic        o_resp_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [7:0]  o_mem_wdata;
    logic        i_mem_ack;
    logic [7:0]  i_mem_rdata;

    always #5 clk = ~clk;

    lsu_byte_master #(.MAX_WAIT(15)) u_dut (
        .clk            (clk),
        .rstn           (rstn),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_addr     (i_req_addr),
        .i_req_wdata    (i_req_wdata),
        .i_req_write    (i_req_write),
        .i_req_type     (i_req_type),
        .i_req_unsigned (i_req_unsigned),
        .o_resp_valid   (o_resp_valid),
        .i_resp_ready   (i_resp_ready),
        .o_resp_rdata   (o_resp_rdata),
        .o_resp_err     (o_resp_err),
        .o_mem_req      (o_mem_req),
        .o_mem_we       (o_mem_we),
        .o_mem_addr     (o_mem_addr),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_ack      (i_mem_ack),
        .i_mem_rdata    (i_mem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model: read-only contents, ack after ack_delay wait cycles, at most ack_limit acks per op
    int          ack_delay = 0;
    int          ack_limit = -1;
    int          log_base = 0;
    int          log_n = 0;
    int          wait_cnt = 0;
    int          req_cycles = 0;
    int          unstable = 0;
    logic [7:0]  rmem [0:255];
    logic [31:0] log_addr [0:63];
    logic [7:0]  log_data [0:63];
    logic        log_we [0:63];
    logic        held_valid = 1'b0;
    logic [31:0] held_addr = 32'd0;

    always_comb begin
        i_mem_ack   = o_mem_req && (wait_cnt >= ack_delay)
                      && ((ack_limit < 0) || ((log_n - log_base) < ack_limit));
        i_mem_rdata = rmem[o_mem_addr[7:0]];
    end

    always @(posedge clk) begin
        if (o_mem_req) req_cycles <= req_cycles + 1;
        if (o_mem_req && i_mem_ack) begin
            log_addr[log_n % 64] <= o_mem_addr;
            log_data[log_n % 64] <= o_mem_wdata;
            log_we[log_n % 64]   <= o_mem_we;
            log_n <= log_n + 1;
        end
        wait_cnt   <= (!o_mem_req || i_mem_ack) ? 0 : wait_cnt + 1;
        held_valid <= o_mem_req && !i_mem_ack;
        held_addr  <= o_mem_addr;
    end

    always @(negedge clk) begin
        if (held_valid && o_mem_req && (o_mem_addr !== held_addr)) unstable <= unstable + 1;
    end

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic [1:0] t, input logic u);
        @(negedge clk);
        check("req_ready_before_send", o_req_ready, 1'b1);
        i_req_addr = a; i_req_wdata = d; i_req_write = w;
        i_req_type = t; i_req_unsigned = u; i_req_valid = 1'b1;
        log_base = log_n;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
    endtask

    task automatic wait_resp(output logic [31:0] rd, output logic e, output int lat);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (o_resp_valid) break;
        end
        check("resp_seen", o_resp_valid, 1'b1);
        rd = o_resp_rdata;
        e  = o_resp_err;
    endtask

    task automatic ack_resp;
        i_resp_ready = 1'b1;
        @(posedge clk);
        #1 i_resp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;
    int          snap;
    logic [31:0] exp_w;

    initial begin
        for (int i = 0; i < 256; i++) rmem[i] = 8'h00;
        rmem[8'h13] = 8'h80; rmem[8'h20] = 8'h34; rmem[8'h21] = 8'hF2;
        rmem[8'hFF] = 8'h11; rmem[8'h00] = 8'h22; rmem[8'h01] = 8'h33; rmem[8'h02] = 8'h44;
        rmem[8'h50] = 8'h00; rmem[8'h51] = 8'h80; rmem[8'h70] = 8'h7F;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready",  o_req_ready,  1'b1);
        check("rst_resp_valid", o_resp_valid, 1'b0);
        check("rst_resp_err",   o_resp_err,   1'b0);
        check("rst_resp_rdata", o_resp_rdata, 32'd0);
        check("rst_mem_req",    o_mem_req,    1'b0);
        check("rst_mem_we",     o_mem_we,     1'b0);
        check("rst_mem_addr",   o_mem_addr,   32'd0);
        check("rst_mem_wdata",  o_mem_wdata,  8'd0);
        @(negedge clk) rstn = 1'b1;

        // Signed byte load, same-cycle ack
        send(32'h13, 32'd0, 1'b0, 2'b00, 1'b0);
        wait_resp(rd, e, lat);
        check("lb_rdata", rd, 32'hFFFFFF80);
        check("lb_err", e, 1'b0);
        check("lb_latency", lat, 2);
        check("lb_nacc", log_n - log_base, 1);
        check("lb_addr", log_addr[log_base % 64], 32'h13);
        check("lb_we", log_we[log_base % 64], 1'b0);
        ack_resp();

        // Word store across an unaligned address
        exp_w = 32'hDEADBEEF;
        send(32'h0E, exp_w, 1'b1, 2'b10, 1'b0);
        wait_resp(rd, e, lat);
        check("sw_rdata", rd, 32'd0);
        check("sw_err", e, 1'b0);
        check("sw_latency", lat, 5);
        check("sw_nacc", log_n - log_base, 4);
        for (int i = 0; i < 4; i++) begin
            check("sw_addr", log_addr[(log_base + i) % 64], 32'h0E + i);
            check("sw_data", log_data[(log_base + i) % 64], exp_w[8*i +: 8]);
            check("sw_we", log_we[(log_base + i) % 64], 1'b1);
        end
        ack_resp();

        // Unsigned half load with 3 wait cycles per byte
        ack_delay = 3;
        snap = unstable;
        send(32'h20, 32'd0, 1'b0, 2'b01, 1'b1);
        wait_resp(rd, e, lat);
        check("lhu_rdata", rd, 32'h0000F234);
        check("lhu_err", e, 1'b0);
        check("lhu_latency", lat, 9);
        check("lhu_addr_stable", unstable - snap, 0);
        ack_resp();

        // Word load wrapping past the top of the address space
        ack_delay = 0;
        send(32'hFFFFFFFF, 32'd0, 1'b0, 2'b10, 1'b0);
        wait_resp(rd, e, lat);
        check("lw_wrap_rdata", rd, 32'h44332211);
        check("lw_wrap_a0", log_addr[(log_base + 0) % 64], 32'hFFFFFFFF);
        check("lw_wrap_a1", log_addr[(log_base + 1) % 64], 32'h00000000);
        check("lw_wrap_a2", log_addr[(log_base + 2) % 64], 32'h00000001);
        check("lw_wrap_a3", log_addr[(log_base + 3) % 64], 32'h00000002);
        ack_resp();

        // Timeout: byte 0 acked, byte 1 never acked
        ack_limit = 1;
        send(32'h40, 32'hCAFEF00D, 1'b1, 2'b10, 1'b0);
        wait_resp(rd, e, lat);
        check("to_err", e, 1'b1);
        check("to_rdata", rd, 32'd0);
        check("to_latency", lat, 17);
        check("to_nacc", log_n - log_base, 1);
        check("to_addr0", log_addr[log_base % 64], 32'h40);
        check("to_data0", log_data[log_base % 64], 8'h0D);
        ack_resp();
        ack_limit = -1;

        // Illegal type: error without any memory access
        snap = req_cycles;
        send(32'h80, 32'd0, 1'b0, 2'b11, 1'b0);
        wait_resp(rd, e, lat);
        check("ill_err", e, 1'b1);
        check("ill_rdata", rd, 32'd0);
        check("ill_latency", lat, 1);
        check("ill_no_mem_req", req_cycles - snap, 0);
        ack_resp();

        // Backpressure with a competing request held valid
        send(32'h50, 32'd0, 1'b0, 2'b01, 1'b0);
        wait_resp(rd, e, lat);
        check("bp_rdata", rd, 32'hFFFF8000);
        i_req_addr = 32'h13; i_req_wdata = 32'd0; i_req_write = 1'b0;
        i_req_type = 2'b00; i_req_unsigned = 1'b0; i_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_held", o_resp_valid, 1'b1);
            check("bp_rdata_held", o_resp_rdata, 32'hFFFF8000);
            check("bp_err_held", o_resp_err, 1'b0);
            check("bp_ready_low", o_req_ready, 1'b0);
        end
        ack_resp();
        @(negedge clk);
        check("bp_idle_after_hs", o_req_ready, 1'b1);
        check("bp_not_taken_early", o_mem_req, 1'b0);
        log_base = log_n;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
        wait_resp(rd, e, lat);
        check("bp_next_rdata", rd, 32'hFFFFFF80);
        check("bp_next_latency", lat, 2);
        ack_resp();

        // Asynchronous reset in the middle of a word load
        ack_limit = 2;
        send(32'h60, 32'd0, 1'b0, 2'b10, 1'b0);
        repeat (3) @(negedge clk);
        check("rm_mem_req_pre", o_mem_req, 1'b1);
        check("rm_addr_pre", o_mem_addr, 32'h62);
        #2 rstn = 1'b0;
        #1;
        check("rm_mem_req_async", o_mem_req, 1'b0);
        check("rm_resp_valid_async", o_resp_valid, 1'b0);
        check("rm_ready_async", o_req_ready, 1'b1);
        @(negedge clk) rstn = 1'b1;
        ack_limit = -1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rm_no_resp", o_resp_valid, 1'b0);
        end
        send(32'h70, 32'd0, 1'b0, 2'b00, 1'b0);
        wait_resp(rd, e, lat);
        check("rm_after_rdata", rd, 32'h0000007F);
        check("rm_after_err", e, 1'b0);
        ack_resp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
